// File: rtl/state_ff.sv
// Generic D/T/JK/SR flip-flop bank, behaviour chosen by FF_TYPE at elaboration.
// Optional clock enable port ce when STATEFF_CE_EN is defined.
module state_ff #(
  parameter string      FF_TYPE     = "DFF",
  parameter int         WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
`ifdef STATEFF_CE_EN
  input  logic             ce,
`endif
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic [WIDTH-1:0] sr_err
);

  localparam int MODE_D  = 0;
  localparam int MODE_T  = 1;
  localparam int MODE_JK = 2;
  localparam int MODE_SR = 3;

  localparam int MODE = (FF_TYPE == "TFF")  ? MODE_T  :
                        (FF_TYPE == "JKFF") ? MODE_JK :
                        (FF_TYPE == "SRFF") ? MODE_SR : MODE_D;

  generate
    if (FF_TYPE != "DFF" && FF_TYPE != "TFF" && FF_TYPE != "JKFF" && FF_TYPE != "SRFF") begin : g_bad_type
      $error("state_ff: unsupported FF_TYPE %s", FF_TYPE);
    end
  endgenerate

  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] err_next;
  logic             upd;

`ifdef STATEFF_CE_EN
  assign upd = ce;
`else
  assign upd = 1'b1;
`endif

  // Characteristic equations; D doubles as T, J or S and K as K or R.
  always_comb begin
    q_next   = Q;
    err_next = '0;
    case (MODE)
      MODE_T:  q_next = Q ^ D;
      MODE_JK: q_next = (D & ~Q) | (~K & Q);
      MODE_SR: begin
        q_next   = ~K & (D | Q);
        err_next = D & K;
      end
      default: q_next = D;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      Q      <= RESET_VALUE;
      sr_err <= '0;
    end else if (upd) begin
      Q      <= q_next;
      sr_err <= err_next;
    end
  end

  assign Qn = ~Q;

endmodule

// File: tb/tb_state_ff.sv
// Randomized and directed bench for state_ff in all four modes, checked against
// a per-bit truth-table model; honours STATEFF_CE_EN when defined.
module tb_state_ff;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ce  = 1'b1;
  logic [0:0] d_dff = '0, d_tff = '0, d_t1 = '0, k1 = '0;
  logic [3:0] j = '0, kj = '0, s = '0, r = '0;

  logic [0:0] q_dff, qn_dff, e_dff, q_tff, qn_tff, e_tff, q_t1, qn_t1, e_t1;
  logic [3:0] q_jk, qn_jk, e_jk, q_sr, qn_sr, e_sr;

  logic [3:0] m_dff, m_tff, m_t1, m_jk, m_sr, me_sr;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

`ifdef STATEFF_CE_EN
  `define CE_CONN .ce(ce),
`else
  `define CE_CONN
`endif

  state_ff #(.FF_TYPE("DFF"), .WIDTH(1)) u_dff (.clk(clk), .rst(rst), `CE_CONN
    .D(d_dff), .K(k1), .Q(q_dff), .Qn(qn_dff), .sr_err(e_dff));
  state_ff #(.FF_TYPE("TFF"), .WIDTH(1)) u_tff (.clk(clk), .rst(rst), `CE_CONN
    .D(d_tff), .K(k1), .Q(q_tff), .Qn(qn_tff), .sr_err(e_tff));
  state_ff #(.FF_TYPE("TFF"), .WIDTH(1), .RESET_VALUE(1'b1)) u_t1 (.clk(clk), .rst(rst), `CE_CONN
    .D(d_t1), .K(k1), .Q(q_t1), .Qn(qn_t1), .sr_err(e_t1));
  state_ff #(.FF_TYPE("JKFF"), .WIDTH(4)) u_jk (.clk(clk), .rst(rst), `CE_CONN
    .D(j), .K(kj), .Q(q_jk), .Qn(qn_jk), .sr_err(e_jk));
  state_ff #(.FF_TYPE("SRFF"), .WIDTH(4)) u_sr (.clk(clk), .rst(rst), `CE_CONN
    .D(s), .K(r), .Q(q_sr), .Qn(qn_sr), .sr_err(e_sr));

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Truth-table model: mode 0=D 1=T 2=JK 3=SR; returns next state per bit.
  function automatic logic [3:0] model_next(input int mode, input logic [3:0] q,
                                            input logic [3:0] a, input logic [3:0] b);
    logic [3:0] n;
    for (int i = 0; i < 4; i++) begin
      case (mode)
        0: n[i] = a[i];
        1: n[i] = a[i] ? !q[i] : q[i];
        2: case ({a[i], b[i]})
             2'b00: n[i] = q[i];
             2'b01: n[i] = 1'b0;
             2'b10: n[i] = 1'b1;
             default: n[i] = !q[i];
           endcase
        default: case ({a[i], b[i]})
             2'b00: n[i] = q[i];
             2'b10: n[i] = 1'b1;
             default: n[i] = 1'b0;
           endcase
      endcase
    end
    return n;
  endfunction

  task automatic tick();
    logic en;
`ifdef STATEFF_CE_EN
    en = ce;
`else
    en = 1'b1;
`endif
    @(posedge clk);
    if (!rst) begin
      m_dff = 4'h0; m_tff = 4'h0; m_t1 = 4'h1; m_jk = 4'h0; m_sr = 4'h0; me_sr = 4'h0;
    end else if (en) begin
      m_dff = model_next(0, m_dff, {3'b0, d_dff}, 4'h0) & 4'h1;
      m_tff = model_next(1, m_tff, {3'b0, d_tff}, 4'h0) & 4'h1;
      m_t1  = model_next(1, m_t1,  {3'b0, d_t1},  4'h0) & 4'h1;
      m_jk  = model_next(2, m_jk, j, kj);
      m_sr  = model_next(3, m_sr, s, r);
      me_sr = s & r;
    end
    #1;
    chk("dff_q",   {3'b0, q_dff},  m_dff);
    chk("dff_qn",  {3'b0, qn_dff}, ~m_dff & 4'h1);
    chk("tff_q",   {3'b0, q_tff},  m_tff);
    chk("tff_qn",  {3'b0, qn_tff}, ~m_tff & 4'h1);
    chk("tff1_q",  {3'b0, q_t1},   m_t1);
    chk("tff1_qn", {3'b0, qn_t1},  ~m_t1 & 4'h1);
    chk("jk_q",    q_jk,  m_jk);
    chk("jk_qn",   qn_jk, ~m_jk);
    chk("sr_q",    q_sr,  m_sr);
    chk("sr_qn",   qn_sr, ~m_sr);
    chk("sr_err",  e_sr,  me_sr);
    chk("noerr",   {1'b0, e_dff, e_tff, e_t1} | e_jk, 4'h0);
  endtask

  initial begin
    logic [3:0] held;
    m_dff = 'x; m_tff = 'x; m_t1 = 'x; m_jk = 'x; m_sr = 'x; me_sr = 'x;

    // reset held two edges
    tick();
    tick();
    chk("rst_dff_q", {3'b0, q_dff}, 4'h0);
    chk("rst_dff_qn", {3'b0, qn_dff}, 4'h1);
    chk("rst_t1_q", {3'b0, q_t1}, 4'h1);

    // TFF toggling from reset
    rst = 1'b1; d_tff = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("tff_seq", {3'b0, q_tff}, (i % 2 == 0) ? 4'h1 : 4'h0);
    end
    d_tff = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("tff_hold", {3'b0, q_tff}, 4'h0);
    end

    // JK directed
    j = 4'b1010; kj = 4'h0; tick(); chk("jk_set", q_jk, 4'b1010);
    j = 4'hF;    kj = 4'hF; tick(); chk("jk_tog", q_jk, 4'b0101);
    j = 4'h0;    kj = 4'hF; tick(); chk("jk_clr", q_jk, 4'h0);

    // SR directed
    s = 4'hF; r = 4'h0; tick(); chk("sr_set_q", q_sr, 4'hF); chk("sr_set_e", e_sr, 4'h0);
    s = 4'hF; r = 4'hF; tick(); chk("sr_both_q", q_sr, 4'h0); chk("sr_both_e", e_sr, 4'hF);
    s = 4'h0; r = 4'h0; tick(); chk("sr_hold_q", q_sr, 4'h0); chk("sr_hold_e", e_sr, 4'h0);

    // reset in the middle of toggling
    d_tff = 1'b1; d_t1 = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b0; tick();
    chk("mid_rst_t1_q", {3'b0, q_t1}, 4'h1);
    chk("mid_rst_t1_qn", {3'b0, qn_t1}, 4'h0);
    chk("mid_rst_tff_q", {3'b0, q_tff}, 4'h0);
    rst = 1'b1; tick();
    chk("resume_t1_q", {3'b0, q_t1}, 4'h0);
    chk("resume_tff_q", {3'b0, q_tff}, 4'h1);

`ifdef STATEFF_CE_EN
    ce = 1'b0;
    held = m_dff;
    for (int i = 0; i < 3; i++) begin
      d_dff = ~q_dff; j = 4'hF; kj = 4'hF; d_tff = 1'b1;
      tick();
      chk("ce_hold_dff", {3'b0, q_dff}, held);
    end
    rst = 1'b0; tick();
    chk("ce_rst_t1", {3'b0, q_t1}, 4'h1);
    chk("ce_rst_jk", q_jk, 4'h0);
    rst = 1'b1; ce = 1'b1;
`else
    held = 4'h0;
`endif

    // randomized traffic with occasional reset
    for (int i = 0; i < 200; i++) begin
      d_dff = 1'($urandom); d_tff = 1'($urandom); d_t1 = 1'($urandom);
      j = 4'($urandom); kj = 4'($urandom); s = 4'($urandom); r = 4'($urandom);
      rst = ($urandom_range(0, 15) != 0);
`ifdef STATEFF_CE_EN
      ce = ($urandom_range(0, 3) != 0);
`endif
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
